// File: rtl/seed_hit_scanner.sv
// seed_hit_scanner: holds one query and streams database beats. Every database seed
// position is compared against all query word positions in parallel. Every match is
// reported as a {db_pos, q_pos} record through a small hit FIFO.
// Optional build macro: SEED_HIT_MASK_EN adds query_mask. Masked query word positions
// are never reported.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   query, query_valid        query load (S_IDLE only); query_ready high in S_IDLE
//   query_mask                (SEED_HIT_MASK_EN only) per-word-position suppress mask
//   db_data, db_valid, db_last, db_ready   database beat stream
//   stop                      synchronous abort back to S_IDLE, FIFO flushed
//   hit_valid, hit_ready, hit_db_pos, hit_q_pos   hit record stream
//   busy, scan_done           status; scan_done pulses once per completed scan
module seed_hit_scanner #(
  parameter  int unsigned QUERY_NT   = 256,
  parameter  int unsigned WORD_NT    = 11,
  parameter  int unsigned DB_BITS    = 512,
  parameter  int unsigned FIFO_DEPTH = 8,
  localparam int unsigned NPOS       = QUERY_NT - WORD_NT + 1,
  localparam int unsigned QPOS_W     = $clog2(NPOS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*QUERY_NT-1:0] query,
`ifdef SEED_HIT_MASK_EN
  input  logic [NPOS-1:0]       query_mask,
`endif
  input  logic                  query_valid,
  output logic                  query_ready,
  input  logic [DB_BITS-1:0]    db_data,
  input  logic                  db_valid,
  input  logic                  db_last,
  output logic                  db_ready,
  input  logic                  stop,
  output logic                  hit_valid,
  input  logic                  hit_ready,
  output logic [31:0]           hit_db_pos,
  output logic [QPOS_W-1:0]     hit_q_pos,
  output logic                  busy,
  output logic                  scan_done
);

  localparam int unsigned NT_BEAT   = DB_BITS / 2;
  localparam int unsigned SEED_W    = 2 * WORD_NT;
  localparam int unsigned CARRY_W   = 2 * (WORD_NT - 1);
  localparam int unsigned EXT_W     = DB_BITS + CARRY_W;
  localparam int unsigned EXT_IDX_W = $clog2(EXT_W);
  localparam int unsigned POS_W     = $clog2(NT_BEAT);
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CMP, S_EMIT, S_DONE} stateT;

  stateT                 state;
  logic [2*QUERY_NT-1:0] queryReg;
  logic [DB_BITS-1:0]    beatReg;
  logic                  lastReg;
  logic [CARRY_W-1:0]    carryReg;
  logic [POS_W-1:0]      pos;
  logic [31:0]           beatCnt;
  logic [NPOS-1:0]       matchReg;

  logic [EXT_W-1:0]      ext;
  logic [EXT_IDX_W-1:0]  seedLsb;
  logic [SEED_W-1:0]     seed;
  logic [NPOS-1:0]       matchVec;
  logic [QPOS_W-1:0]     lowIdx;
  logic [31:0]           seedStart;

  logic [31:0]           memDb [FIFO_DEPTH];
  logic [QPOS_W-1:0]     memQ  [FIFO_DEPTH];
  logic [PTR_W-1:0]      wrPtr;
  logic [PTR_W-1:0]      rdPtr;
  logic [CNT_W-1:0]      fifoCnt;
  logic [CNT_W-1:0]      nextCnt;
  logic                  popEn;
  logic                  canPush;
  logic                  pushEn;

`ifdef SEED_HIT_MASK_EN
  logic [NPOS-1:0]       maskReg;
`endif

  // Seed ending at beat nucleotide pos, taken from the carry-extended window.
  always_comb begin
    ext      = {beatReg, carryReg};
    seedLsb  = EXT_IDX_W'({pos, 1'b0});
    seed     = ext[seedLsb +: SEED_W];
    matchVec = '0;
    for (int i = 0; i < NPOS; i++) begin
      matchVec[i] = (queryReg[2*i +: SEED_W] == seed);
    end
    // The first beat has no history, so its leading positions do not hold a full seed.
    if (beatCnt == '0 && pos < POS_W'(WORD_NT - 1)) begin
      matchVec = '0;
    end
`ifdef SEED_HIT_MASK_EN
    matchVec = matchVec & ~maskReg;
`endif
  end

  // Lowest pending query position and the global start of the current seed.
  always_comb begin
    lowIdx = '0;
    for (int i = NPOS - 1; i >= 0; i--) begin
      if (matchReg[i]) lowIdx = QPOS_W'(i);
    end
    seedStart = beatCnt * 32'(NT_BEAT) + 32'(pos) - 32'(WORD_NT - 1);
  end

  // FIFO handshake. A full FIFO still accepts a push when its head leaves that cycle.
  always_comb begin
    popEn   = hit_valid & hit_ready;
    canPush = (fifoCnt != CNT_W'(FIFO_DEPTH)) || popEn;
    pushEn  = (state == S_EMIT) && (matchReg != '0) && canPush && !stop;
    nextCnt = fifoCnt + CNT_W'(pushEn) - CNT_W'(popEn);
  end

  assign hit_db_pos = memDb[rdPtr];
  assign hit_q_pos  = memQ[rdPtr];

  // Hit storage. Data only, no reset needed.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      memDb[wrPtr] <= seedStart;
      memQ[wrPtr]  <= lowIdx;
    end
  end

  // FIFO pointers and occupancy. hit_valid is registered from the next occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCnt   <= '0;
      hit_valid <= 1'b0;
    end else if (stop) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCnt   <= '0;
      hit_valid <= 1'b0;
    end else begin
      if (pushEn) wrPtr <= wrPtr + 1'b1;
      if (popEn)  rdPtr <= rdPtr + 1'b1;
      fifoCnt   <= nextCnt;
      hit_valid <= (nextCnt != '0);
    end
  end

  // Scan control. Status outputs are updated together with each state transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      queryReg    <= '0;
      beatReg     <= '0;
      lastReg     <= 1'b0;
      carryReg    <= '0;
      pos         <= '0;
      beatCnt     <= '0;
      matchReg    <= '0;
      query_ready <= 1'b1;
      db_ready    <= 1'b0;
      busy        <= 1'b0;
      scan_done   <= 1'b0;
`ifdef SEED_HIT_MASK_EN
      maskReg     <= '0;
`endif
    end else if (stop) begin
      state       <= S_IDLE;
      matchReg    <= '0;
      beatCnt     <= '0;
      carryReg    <= '0;
      query_ready <= 1'b1;
      db_ready    <= 1'b0;
      busy        <= 1'b0;
      scan_done   <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (query_valid) begin
            queryReg    <= query;
`ifdef SEED_HIT_MASK_EN
            maskReg     <= query_mask;
`endif
            // A new query starts a new database scan at nucleotide 0.
            beatCnt     <= '0;
            carryReg    <= '0;
            state       <= S_FETCH;
            query_ready <= 1'b0;
            db_ready    <= 1'b1;
            busy        <= 1'b1;
          end
        end
        S_FETCH: begin
          if (db_valid) begin
            beatReg  <= db_data;
            lastReg  <= db_last;
            pos      <= '0;
            state    <= S_CMP;
            db_ready <= 1'b0;
          end
        end
        S_CMP: begin
          matchReg <= matchVec;
          state    <= S_EMIT;
        end
        S_EMIT: begin
          if (matchReg != '0) begin
            if (canPush) matchReg[lowIdx] <= 1'b0;
          end else if (pos != POS_W'(NT_BEAT - 1)) begin
            pos   <= pos + 1'b1;
            state <= S_CMP;
          end else begin
            carryReg <= beatReg[DB_BITS-1 -: CARRY_W];
            beatCnt  <= beatCnt + 32'd1;
            if (lastReg) begin
              state <= S_DONE;
            end else begin
              state    <= S_FETCH;
              db_ready <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (fifoCnt == '0) begin
            state       <= S_IDLE;
            scan_done   <= 1'b1;
            busy        <= 1'b0;
            query_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seed_hit_scanner.sv
// Self-checking bench for seed_hit_scanner. It uses random queries and databases with
// planted words. Each scan is compared against a brute-force seed search over nucleotide
// arrays. Directed cases cover FIFO backpressure, stop, async reset and the optional mask.
module tb_seed_hit_scanner;
  localparam int QUERY_NT = 256;
  localparam int WORD_NT  = 11;
  localparam int DB_BITS  = 512;
  localparam int NT_BEAT  = 256;
  localparam int NPOS     = QUERY_NT - WORD_NT + 1;
  localparam int QPOS_W   = 8;
  localparam int MAXB     = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [2*QUERY_NT-1:0] query;
  logic                  query_valid;
  logic                  query_ready;
  logic [DB_BITS-1:0]    db_data;
  logic                  db_valid;
  logic                  db_last;
  logic                  db_ready;
  logic                  stop;
  logic                  hit_valid;
  logic                  hit_ready;
  logic [31:0]           hit_db_pos;
  logic [QPOS_W-1:0]     hit_q_pos;
  logic                  busy;
  logic                  scan_done;
`ifdef SEED_HIT_MASK_EN
  logic [NPOS-1:0]       query_mask;
`endif

  always #5 clk = ~clk;

  seed_hit_scanner dut (
    .clk(clk), .rst(rst), .query(query),
`ifdef SEED_HIT_MASK_EN
    .query_mask(query_mask),
`endif
    .query_valid(query_valid), .query_ready(query_ready),
    .db_data(db_data), .db_valid(db_valid), .db_last(db_last), .db_ready(db_ready),
    .stop(stop), .hit_valid(hit_valid), .hit_ready(hit_ready),
    .hit_db_pos(hit_db_pos), .hit_q_pos(hit_q_pos), .busy(busy), .scan_done(scan_done)
  );

  int nVec = 0;
  int nErr = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: the query and database as plain nucleotide arrays.
  logic [1:0]      qNt  [QUERY_NT];
  logic [1:0]      dbNt [MAXB*NT_BEAT];
  int              nBeats;
  logic [NPOS-1:0] maskBits;
  logic [39:0]     expQ[$];
  logic [39:0]     gotQ[$];

  function automatic void buildExpected();
    expQ.delete();
    for (int s = 0; s <= nBeats*NT_BEAT - WORD_NT; s++) begin
      for (int i = 0; i < NPOS; i++) begin
        bit eq = 1'b1;
        if (maskBits[i]) continue;
        for (int k = 0; k < WORD_NT; k++) begin
          if (dbNt[s+k] != qNt[i+k]) begin
            eq = 1'b0;
            break;
          end
        end
        if (eq) expQ.push_back({32'(s), 8'(i)});
      end
    end
  endfunction

  function automatic void randomFill(input int nb);
    nBeats = nb;
    for (int n = 0; n < QUERY_NT; n++) qNt[n] = 2'($urandom_range(3));
    for (int n = 0; n < MAXB*NT_BEAT; n++) dbNt[n] = 2'($urandom_range(3));
  endfunction

  // Zero query; database zero for its first 20 nucleotides and nonzero afterwards.
  function automatic void zeroFill();
    nBeats = 1;
    for (int n = 0; n < QUERY_NT; n++) qNt[n] = 2'd0;
    for (int n = 0; n < MAXB*NT_BEAT; n++) dbNt[n] = (n < 20) ? 2'd0 : 2'($urandom_range(3, 1));
  endfunction

  function automatic void plant(input int dbStart, input int qIdx);
    for (int k = 0; k < WORD_NT; k++) dbNt[dbStart+k] = qNt[qIdx+k];
  endfunction

  function automatic logic [2*QUERY_NT-1:0] packQuery();
    logic [2*QUERY_NT-1:0] v;
    for (int n = 0; n < QUERY_NT; n++) v[2*n +: 2] = qNt[n];
    return v;
  endfunction

  function automatic logic [DB_BITS-1:0] packBeat(input int b);
    logic [DB_BITS-1:0] v;
    for (int n = 0; n < NT_BEAT; n++) v[2*n +: 2] = dbNt[b*NT_BEAT+n];
    return v;
  endfunction

  task automatic loadQuery();
    checkVal("query_ready", 64'(query_ready), 64'd1);
    query = packQuery();
`ifdef SEED_HIT_MASK_EN
    query_mask = maskBits;
`endif
    query_valid = 1'b1;
    @(negedge clk);
    query_valid = 1'b0;
  endtask

  // One full scan. Inputs are driven and outputs sampled at negedges.
  task automatic runScan(input string name, input int readyPct, input int validPct,
                         input int holdCycles, input bit checkLat);
    int cyc = 0;
    int beatIdx = 0;
    int acceptCyc = -1;
    int firstHit = -1;
    bit done = 1'b0;
    int errBefore;
    buildExpected();
    gotQ.delete();
    loadQuery();
    while (!done && cyc < 20000) begin
      cyc++;
      if (holdCycles > 0 && cyc == holdCycles) begin
        checkVal({name, "_stall_valid"}, 64'(hit_valid), 64'd1);
        checkVal({name, "_stall_db_ready"}, 64'(db_ready), 64'd0);
        checkVal({name, "_stall_busy"}, 64'(busy), 64'd1);
        checkVal({name, "_stall_head"}, 64'({hit_db_pos, hit_q_pos}), 64'(expQ[0]));
      end
      hit_ready = (cyc > holdCycles) && ($urandom_range(99) < readyPct);
      if (hit_valid && firstHit < 0) firstHit = cyc;
      if (hit_valid && hit_ready) gotQ.push_back({hit_db_pos, hit_q_pos});
      db_valid = 1'b0;
      if (beatIdx < nBeats && db_ready && $urandom_range(99) < validPct) begin
        db_valid = 1'b1;
        db_data  = packBeat(beatIdx);
        db_last  = (beatIdx == nBeats - 1);
        if (beatIdx == 0) acceptCyc = cyc;
        beatIdx++;
      end
      if (scan_done) done = 1'b1;
      @(negedge clk);
    end
    db_valid  = 1'b0;
    hit_ready = 1'b0;
    checkVal({name, "_scan_done"}, 64'(done), 64'd1);
    checkVal({name, "_hit_count"}, 64'(gotQ.size()), 64'(expQ.size()));
    errBefore = nErr;
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      checkVal($sformatf("%s_hit%0d", name, i), 64'(gotQ[i]), 64'(expQ[i]));
      if (nErr != errBefore) break;
    end
    if (checkLat && expQ.size() > 0 && int'(expQ[0][39:8]) + WORD_NT - 1 < NT_BEAT)
      checkVal({name, "_latency"}, 64'(firstHit - acceptCyc),
               64'(3 + 2*(int'(expQ[0][39:8]) + WORD_NT - 1)));
    checkVal({name, "_idle_busy"}, 64'(busy), 64'd0);
    checkVal({name, "_idle_qready"}, 64'(query_ready), 64'd1);
  endtask

  task automatic waitDbReady(input string tag);
    int t = 0;
    while (!db_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    checkVal(tag, 64'(db_ready), 64'd1);
  endtask

  initial begin
    int t;
    rst = 1'b0; query = '0; query_valid = 1'b0; db_data = '0; db_valid = 1'b0;
    db_last = 1'b0; stop = 1'b0; hit_ready = 1'b0; maskBits = '0;
`ifdef SEED_HIT_MASK_EN
    query_mask = '0;
`endif
    @(negedge clk);
    checkVal("rst_query_ready", 64'(query_ready), 64'd1);
    checkVal("rst_busy", 64'(busy), 64'd0);
    checkVal("rst_hit_valid", 64'(hit_valid), 64'd0);
    checkVal("rst_db_ready", 64'(db_ready), 64'd0);
    checkVal("rst_scan_done", 64'(scan_done), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Word at q_pos 10 planted at nucleotides 20..30 of a single beat.
    randomFill(1);
    plant(20, 10);
    runScan("single", 100, 100, 0, 1'b1);

    // Word split across the beat boundary.
    randomFill(2);
    plant(251, 37);
    runScan("split", 70, 80, 0, 1'b0);

    // Backpressure: the FIFO fills and the scan stalls until hit_ready is released.
    zeroFill();
    runScan("stall", 100, 100, 40, 1'b0);

    // stop while hits are queued.
    zeroFill();
    loadQuery();
    waitDbReady("stop_db_ready");
    db_valid = 1'b1; db_data = packBeat(0); db_last = 1'b1;
    @(negedge clk);
    db_valid = 1'b0;
    t = 0;
    while (!hit_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    checkVal("stop_pre_valid", 64'(hit_valid), 64'd1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checkVal("stop_hit_valid", 64'(hit_valid), 64'd0);
    checkVal("stop_query_ready", 64'(query_ready), 64'd1);
    checkVal("stop_busy", 64'(busy), 64'd0);
    checkVal("stop_db_ready", 64'(db_ready), 64'd0);
    randomFill(2);
    plant(3, 100);
    plant(300, 5);
    runScan("after_stop", 60, 70, 0, 1'b0);

    // Asynchronous reset while the first compare is in flight.
    randomFill(1);
    loadQuery();
    waitDbReady("arst_db_ready");
    db_valid = 1'b1; db_data = packBeat(0); db_last = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkVal("arst_query_ready", 64'(query_ready), 64'd1);
    checkVal("arst_busy", 64'(busy), 64'd0);
    checkVal("arst_db_ready", 64'(db_ready), 64'd0);
    checkVal("arst_hit_valid", 64'(hit_valid), 64'd0);
    checkVal("arst_scan_done", 64'(scan_done), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    db_valid = 1'b0;
    @(negedge clk);

    // Random scans with several planted words.
    for (int r = 0; r < 3; r++) begin
      randomFill($urandom_range(3, 1));
      for (int p = 0; p < 4; p++)
        plant($urandom_range(nBeats*NT_BEAT - WORD_NT), $urandom_range(NPOS - 1));
      runScan($sformatf("rand%0d", r), $urandom_range(100, 30), 60, 0, 1'b0);
    end

`ifdef SEED_HIT_MASK_EN
    // Masked word position: same stimulus shape as the single-hit case.
    randomFill(1);
    plant(20, 10);
    maskBits = '0;
    maskBits[10] = 1'b1;
    runScan("mask", 100, 100, 0, 1'b0);
    maskBits = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
